// File: rtl/svc_soc_uart_tx_if.sv
// Byte stream handshake into the UART transmitter queue.
interface svc_soc_uart_tx_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/svc_soc_uart_tx.sv
// Buffered 8N1 UART transmitter: byte queue feeding a back-to-back serializer.
// Define SVC_SOC_UART_TX_FIFO_EN for a FIFO_DEPTH-byte queue; otherwise a single holding register.
module svc_soc_uart_tx #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned LEVEL_W   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    svc_soc_uart_tx_if.slave   s_bus,
    output logic               txd,
    output logic               busy,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_baud_check
        $fatal(1, "svc_soc_uart_tx: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                txd_q, txd_d;
    logic                busy_q;
    logic                ready_q;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic                push_c, pop_c, baud_done_c;
    logic [7:0]          head_c;

    assign push_c      = s_bus.s_valid && ready_q;
    assign baud_done_c = (baud_q == BAUD_LAST);
    assign level_d     = level_q + LEVEL_W'(push_c) - LEVEL_W'(pop_c);

`ifdef SVC_SOC_UART_TX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $fatal(1, "svc_soc_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= s_bus.s_data;
    end

    // Pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign head_c = mem[rd_ptr_q];
`else
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(1);

    logic [7:0] hold_q;

    always_ff @(posedge clk) begin
        if (push_c) hold_q <= s_bus.s_data;
    end

    assign head_c = hold_q;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; STOP chains straight into START when bytes are pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (level_q != '0) state_d = START;
            START:   if (baud_done_c) state_d = DATA;
            DATA:    if (baud_done_c && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:    if (baud_done_c) state_d = (level_q != '0) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        pop_c     = 1'b0;
        baud_d    = baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = 1'b1;
        if (state_d != state_q) baud_d = '0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (state_d == START) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                end
            end
            START: if (baud_done_c) bit_idx_d = '0;
            DATA: if (baud_done_c) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + 3'd1;
                baud_d    = '0;
            end
            STOP: if (state_d == START) begin
                pop_c   = 1'b1;
                shift_d = head_c;
            end
            default: ;
        endcase
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Registered datapath and outputs; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            level_q   <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            level_q   <= level_d;
            ready_q   <= (level_d != FULL_LEVEL);
            busy_q    <= (state_d != IDLE) || (level_d != '0);
        end
    end

    assign s_bus.s_ready = ready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;
    assign level         = level_q;

endmodule
